// File: rtl/instr_mem_prog.sv
// Loadable instruction memory: words stream in over a valid/ready port, fetch returns mem[pc_in] one clock later.
// Backpressure: prog_ready is high only in LOAD (and not on a restart cycle); fetch_en=0 holds the fetch outputs.
module instr_mem_prog #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic              prog_last,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              load_ovf,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              pc_ok;
  logic              last_word;

  assign wr_en     = prog_valid && prog_ready;
  assign pc_ok     = {1'b0, pc_in} < DEPTH_X;
  assign last_word = prog_last || (wr_ptr == LAST_PTR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (prog_start) state_nxt = LOAD;
      end
      LOAD: begin
        // A restart pulse takes priority, so no word is accepted on that cycle.
        prog_ready = !prog_start;
        if (prog_valid && !prog_start && last_word) state_nxt = DONE;
      end
      DONE: begin
        prog_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage deliberately has no reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      load_ovf    <= 1'b0;
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (prog_start) begin
            wr_ptr   <= '0;
            load_ovf <= 1'b0;
          end
          if (fetch_en) begin
            instr_valid <= 1'b1;
            addr_err    <= !pc_ok;
            instr_out   <= pc_ok ? mem[pc_in[IDX_W-1:0]] : NOP_WORD;
          end
        end
        LOAD: begin
          instr_valid <= 1'b0;
          if (prog_start) begin
            wr_ptr <= '0;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_PTR && !prog_last) load_ovf <= 1'b1;
          end
        end
        default: instr_valid <= 1'b0;
      endcase
    end
  end

endmodule
